// File: rtl/core_sequencer_if.sv
// Bus bundle between the fetch/execute sequencer and its surroundings:
// instruction ROM, decoder flags, data memory handshake and status.
interface core_sequencer_if #(
    parameter int T  = 10,
    parameter int CW = 16
);
    logic          Start;
    logic [8:0]    InstrIn;
    logic          BranchEZ;
    logic          BranchNZ;
    logic          BranchAlways;
    logic          Zero;
    logic [T-1:0]  Target;
    logic          LoadMem;
    logic          write_mem;
    logic          Done_in;
    logic          MemAck;

    logic [T-1:0]  ProgCtr;
    logic [T-1:0]  ProgCtr_p4;
    logic [8:0]    Instruction;
    logic          Commit;
    logic          MemReq;
    logic          MemWe;
    logic          Done;
    logic          Busy;
    logic          Error;
    logic [CW-1:0] RetiredCount;

    // Environment side: drives control, ROM data, decoder flags and memory ack.
    modport master (
        output Start, InstrIn, BranchEZ, BranchNZ, BranchAlways, Zero, Target,
               LoadMem, write_mem, Done_in, MemAck,
        input  ProgCtr, ProgCtr_p4, Instruction, Commit, MemReq, MemWe,
               Done, Busy, Error, RetiredCount
    );

    // Sequencer side.
    modport slave (
        input  Start, InstrIn, BranchEZ, BranchNZ, BranchAlways, Zero, Target,
               LoadMem, write_mem, Done_in, MemAck,
        output ProgCtr, ProgCtr_p4, Instruction, Commit, MemReq, MemWe,
               Done, Busy, Error, RetiredCount
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/execute sequencer for the 9-bit-instruction core.
// Owns the PC and instruction register, resolves branches, runs the
// LDW/STW handshake with a timeout, and gates register writes via Commit.
module core_sequencer #(
    parameter int T           = 10,
    parameter int PC_STEP     = 4,
    parameter int RESET_PC    = 0,
    parameter int MEM_TIMEOUT = 15,
    parameter int CW          = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    core_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [T-1:0]  STEP    = T'(PC_STEP);
    localparam logic [T-1:0]  RST_PC  = T'(RESET_PC);
    localparam logic [7:0]    TMO_LIM = 8'(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t        state, state_n;
    logic [T-1:0]  pc, pc_n;
    logic [8:0]    ir, ir_n;
    logic [CW-1:0] retired, retired_n;
    logic          err, err_n;
    logic [7:0]    tmo_cnt, tmo_n;
    logic          mem_we_q, mem_we_n;
    logic          commit;

    logic [T-1:0]  pc_seq;
    logic [T-1:0]  next_pc;
    logic [7:0]    tmo_inc;
    logic          taken;

    // Sequential PC and branch target resolution; both wrap modulo 2^T.
    assign pc_seq  = pc + STEP;
    assign taken   = bus.BranchAlways | (bus.BranchEZ & bus.Zero) | (bus.BranchNZ & ~bus.Zero);
    assign next_pc = taken ? bus.Target : pc_seq;
    assign tmo_inc = tmo_cnt + 8'd1;

    // State and datapath registers; reset drops any pending memory request.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            pc       <= RST_PC;
            ir       <= '0;
            retired  <= '0;
            err      <= 1'b0;
            tmo_cnt  <= '0;
            mem_we_q <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ir       <= ir_n;
            retired  <= retired_n;
            err      <= err_n;
            tmo_cnt  <= tmo_n;
            mem_we_q <= mem_we_n;
        end
    end

    // Next-state, datapath updates and the Mealy Commit strobe.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        ir_n      = ir;
        retired_n = retired;
        err_n     = err;
        tmo_n     = tmo_cnt;
        mem_we_n  = mem_we_q;
        commit    = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                // Restart from the top; Error is sticky until here.
                if (bus.Start) begin
                    state_n   = S_FETCH;
                    pc_n      = RST_PC;
                    retired_n = '0;
                    err_n     = 1'b0;
                end
            end
            S_FETCH: begin
                ir_n    = bus.InstrIn;
                state_n = S_EXEC;
            end
            S_EXEC: begin
                if (bus.Done_in) begin
                    // DNE halts without retiring.
                    state_n = S_HALT;
                end else if (bus.LoadMem || bus.write_mem) begin
                    // Capture the direction so MemWe stays stable for the whole access.
                    state_n  = S_MEM;
                    tmo_n    = '0;
                    mem_we_n = bus.write_mem;
                end else begin
                    commit    = 1'b1;
                    pc_n      = next_pc;
                    retired_n = retired + CNT_ONE;
                    state_n   = S_FETCH;
                end
            end
            S_MEM: begin
                if (bus.MemAck) begin
                    commit    = 1'b1;
                    pc_n      = pc_seq;
                    retired_n = retired + CNT_ONE;
                    state_n   = S_FETCH;
                end else if (tmo_inc == TMO_LIM) begin
                    // Memory never answered: abort with PC left on the faulting op.
                    tmo_n   = tmo_inc;
                    err_n   = 1'b1;
                    state_n = S_HALT;
                end else begin
                    tmo_n = tmo_inc;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Moore status decode plus pass-through of the datapath registers.
    assign bus.ProgCtr      = pc;
    assign bus.ProgCtr_p4   = pc_seq;
    assign bus.Instruction  = ir;
    assign bus.Commit       = commit;
    assign bus.MemReq       = (state == S_MEM);
    assign bus.MemWe        = (state == S_MEM) && mem_we_q;
    assign bus.Done         = (state == S_HALT);
    assign bus.Busy         = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEM);
    assign bus.Error        = err;
    assign bus.RetiredCount = retired;
endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: sequential flow, branches and wrap,
// STW with delayed ack, LDW timeout, DNE, Start while busy, reset mid-MEM.
module tb_core_sequencer;
    logic Clk;
    logic Reset;
    int   total = 0;
    int   bad   = 0;

    core_sequencer_if #(.T(10), .CW(16)) bus ();

    core_sequencer #(
        .T(10), .PC_STEP(4), .RESET_PC(0), .MEM_TIMEOUT(15), .CW(16)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    task automatic clr_dec();
        bus.BranchEZ     = 1'b0;
        bus.BranchNZ     = 1'b0;
        bus.BranchAlways = 1'b0;
        bus.Zero         = 1'b0;
        bus.Target       = '0;
        bus.LoadMem      = 1'b0;
        bus.write_mem    = 1'b0;
        bus.Done_in      = 1'b0;
    endtask

    // One non-memory instruction from FETCH: latch, execute with given flags, back in FETCH.
    task automatic run_alu(input logic ez, input logic nz, input logic al,
                           input logic z, input logic [9:0] tgt);
        cyc();                       // now EXEC
        bus.BranchEZ = ez; bus.BranchNZ = nz; bus.BranchAlways = al;
        bus.Zero = z; bus.Target = tgt;
        cyc();                       // now FETCH
        clr_dec();
    endtask

    initial begin
        Reset     = 1'b1;
        bus.Start = 1'b0;
        bus.InstrIn = '0;
        bus.MemAck  = 1'b0;
        clr_dec();

        // Reset values
        #12;
        chk("rst_pc",     32'(bus.ProgCtr), 32'h0);
        chk("rst_ir",     32'(bus.Instruction), 32'h0);
        chk("rst_ret",    32'(bus.RetiredCount), 32'h0);
        chk("rst_err",    32'(bus.Error), 32'h0);
        chk("rst_commit", 32'(bus.Commit), 32'h0);
        chk("rst_memreq", 32'(bus.MemReq), 32'h0);
        chk("rst_memwe",  32'(bus.MemWe), 32'h0);
        chk("rst_done",   32'(bus.Done), 32'h0);
        chk("rst_busy",   32'(bus.Busy), 32'h0);
        Reset = 1'b0;

        // Three plain instructions: PC 0 -> 4 -> 8 -> 12, Commit every 2nd cycle
        cyc();
        bus.Start = 1'b1; bus.InstrIn = 9'h011;
        cyc();                                   // FETCH
        bus.Start = 1'b0;
        #1;
        chk("f1_busy",   32'(bus.Busy), 32'h1);
        chk("f1_commit", 32'(bus.Commit), 32'h0);
        chk("f1_pc",     32'(bus.ProgCtr), 32'h0);
        cyc();                                   // EXEC
        #1;
        chk("e1_ir",     32'(bus.Instruction), 32'h011);
        chk("e1_commit", 32'(bus.Commit), 32'h1);
        cyc();                                   // FETCH
        bus.InstrIn = 9'h022;
        #1;
        chk("f2_pc",     32'(bus.ProgCtr), 32'h4);
        chk("f2_commit", 32'(bus.Commit), 32'h0);
        chk("f2_ret",    32'(bus.RetiredCount), 32'h1);
        cyc();                                   // EXEC
        #1;
        chk("e2_commit", 32'(bus.Commit), 32'h1);
        cyc();                                   // FETCH
        bus.InstrIn = 9'h033;
        #1;
        chk("f3_pc",     32'(bus.ProgCtr), 32'h8);
        cyc();                                   // EXEC
        cyc();                                   // FETCH
        #1;
        chk("seq_pc12",  32'(bus.ProgCtr), 32'hC);
        chk("seq_p4",    32'(bus.ProgCtr_p4), 32'h10);
        chk("seq_ret3",  32'(bus.RetiredCount), 32'h3);

        // Branches
        run_alu(1'b0, 1'b1, 1'b0, 1'b0, 10'h100);
        #1;
        chk("bnz_taken", 32'(bus.ProgCtr), 32'h100);
        run_alu(1'b0, 1'b1, 1'b0, 1'b1, 10'h200);
        #1;
        chk("bnz_not",   32'(bus.ProgCtr), 32'h104);
        run_alu(1'b0, 1'b0, 1'b1, 1'b0, 10'h3FC);
        #1;
        chk("ba_3fc",    32'(bus.ProgCtr), 32'h3FC);
        chk("p4_wrap",   32'(bus.ProgCtr_p4), 32'h0);
        run_alu(1'b0, 1'b0, 1'b1, 1'b0, 10'h000);
        #1;
        chk("ba_to0",    32'(bus.ProgCtr), 32'h0);
        run_alu(1'b0, 1'b0, 1'b1, 1'b0, 10'h3FC);
        run_alu(1'b0, 1'b0, 1'b0, 1'b0, 10'h155);
        #1;
        chk("seq_wrap",  32'(bus.ProgCtr), 32'h0);
        run_alu(1'b1, 1'b0, 1'b0, 1'b1, 10'h040);
        #1;
        chk("bez_taken", 32'(bus.ProgCtr), 32'h40);
        chk("br_ret",    32'(bus.RetiredCount), 32'hA);

        // STW, ack after 3 waiting MEM cycles
        cyc();                                   // EXEC
        bus.write_mem = 1'b1;
        #1;
        chk("stw_exec_commit", 32'(bus.Commit), 32'h0);
        chk("stw_exec_req",    32'(bus.MemReq), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();                               // MEM wait cycle
            #1;
            chk("stw_wait_req",    32'({bus.MemReq, bus.MemWe}), 32'h3);
            chk("stw_wait_commit", 32'(bus.Commit), 32'h0);
        end
        cyc();                                   // MEM ack cycle
        bus.MemAck = 1'b1;
        #1;
        chk("stw_ack_req",    32'({bus.MemReq, bus.MemWe}), 32'h3);
        chk("stw_ack_commit", 32'(bus.Commit), 32'h1);
        cyc();                                   // FETCH
        bus.MemAck = 1'b0;
        clr_dec();
        #1;
        chk("stw_after_req", 32'(bus.MemReq), 32'h0);
        chk("stw_pc",        32'(bus.ProgCtr), 32'h44);
        chk("stw_ret",       32'(bus.RetiredCount), 32'hB);

        // LDW that never gets acked: 15 MEM cycles then HALT with Error
        cyc();                                   // EXEC
        bus.LoadMem = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            cyc();                               // MEM cycle i
            #1;
            chk("ldw_wait_req", 32'({bus.MemReq, bus.MemWe, bus.Commit, bus.Done}), 32'h8);
        end
        cyc();                                   // HALT
        bus.LoadMem = 1'b0;
        #1;
        chk("tmo_done",   32'(bus.Done), 32'h1);
        chk("tmo_err",    32'(bus.Error), 32'h1);
        chk("tmo_busy",   32'(bus.Busy), 32'h0);
        chk("tmo_req",    32'(bus.MemReq), 32'h0);
        chk("tmo_commit", 32'(bus.Commit), 32'h0);
        chk("tmo_pc",     32'(bus.ProgCtr), 32'h44);
        chk("tmo_ret",    32'(bus.RetiredCount), 32'hB);

        // Restart from HALT clears Error and the counter
        bus.Start = 1'b1; bus.InstrIn = 9'h055;
        cyc();                                   // FETCH (Start held: must be ignored)
        #1;
        chk("rs_err",  32'(bus.Error), 32'h0);
        chk("rs_pc",   32'(bus.ProgCtr), 32'h0);
        chk("rs_ret",  32'(bus.RetiredCount), 32'h0);
        chk("rs_busy", 32'({bus.Busy, bus.Done}), 32'h2);
        cyc();                                   // EXEC, plain instruction
        bus.Start = 1'b0;
        #1;
        chk("rs_ir",   32'(bus.Instruction), 32'h055);
        cyc();                                   // FETCH at 4
        bus.Start = 1'b1; bus.InstrIn = 9'h1FF;
        cyc();                                   // EXEC despite Start
        bus.Start = 1'b0;
        bus.Done_in = 1'b1;
        #1;
        chk("busy_start_ir", 32'(bus.Instruction), 32'h1FF);
        chk("busy_start_pc", 32'(bus.ProgCtr), 32'h4);
        chk("dne_commit",    32'(bus.Commit), 32'h0);
        cyc();                                   // HALT
        bus.Done_in = 1'b0;
        #1;
        chk("dne_done", 32'({bus.Done, bus.Busy, bus.Error}), 32'h4);
        chk("dne_ret",  32'(bus.RetiredCount), 32'h1);
        chk("dne_pc",   32'(bus.ProgCtr), 32'h4);

        // Reset in the middle of a memory access
        bus.Start = 1'b1;
        cyc();                                   // FETCH at 0
        bus.Start = 1'b0;
        run_alu(1'b0, 1'b0, 1'b0, 1'b0, 10'h000); // back in FETCH at 4
        cyc();                                   // EXEC
        bus.write_mem = 1'b1;
        cyc();                                   // MEM
        #1;
        chk("mid_req", 32'(bus.MemReq), 32'h1);
        chk("mid_pc",  32'(bus.ProgCtr), 32'h4);
        Reset = 1'b1;
        #1;
        chk("mid_rst_req",  32'({bus.MemReq, bus.MemWe}), 32'h0);
        chk("mid_rst_pc",   32'(bus.ProgCtr), 32'h0);
        chk("mid_rst_busy", 32'({bus.Busy, bus.Done}), 32'h0);
        #2;
        Reset = 1'b0;
        clr_dec();
        bus.MemAck = 1'b1;
        #1;
        chk("late_ack_commit0", 32'(bus.Commit), 32'h0);
        cyc();
        #1;
        chk("late_ack_commit1", 32'(bus.Commit), 32'h0);
        chk("late_ack_state",   32'({bus.Busy, bus.MemReq}), 32'h0);
        chk("late_ack_ret",     32'(bus.RetiredCount), 32'h0);
        bus.MemAck = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
